// File: rtl/memory_unit.sv
// 4096 x 16 word memory behind a request FSM with a fixed, parameterised access latency.
// One request in flight at a time; simultaneous rd and wr in IDLE is flagged as an error.
module memory_unit #(
  parameter int LATENCY   = 2,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [11:0] addr,
  input  logic [15:0] wdata,
  input  logic        rd,
  input  logic        wr,
  output logic [15:0] rdata,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int DATA_W = 16;
  localparam int ADDR_W = 12;
  localparam int DEPTH  = 4096;
  localparam logic [3:0] LAT_LOAD = 4'(LATENCY);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t              state, state_nxt;
  logic [3:0]          cnt, cnt_nxt;
  logic                accept, illegal, commit;
  logic [ADDR_W-1:0]   addr_l;
  logic [DATA_W-1:0]   wdata_l;
  logic                op_wr;
  logic [DATA_W-1:0]   mem_q;

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    illegal   = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (rd ^ wr) begin
          accept    = 1'b1;
          state_nxt = WAIT;
          cnt_nxt   = LAT_LOAD;
        end else if (rd && wr) begin
          illegal = 1'b1;
        end
      end
      WAIT: begin
        // The access itself happens on the edge that moves WAIT -> RESP.
        if (cnt == 4'd1) begin
          state_nxt = RESP;
          cnt_nxt   = 4'd0;
          commit    = 1'b1;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
      err   <= 1'b0;
      rdata <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (illegal) err <= 1'b1;
      if (commit && !op_wr) rdata <= mem_q;
    end
  end

  // Request operands are captured once at acceptance so later bus activity is ignored.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_l  <= addr;
      wdata_l <= wdata;
      op_wr   <= wr;
    end
  end

  assign busy = (state != IDLE);
  assign done = (state == RESP);

  generate
    if (INIT_ZERO) begin : g_mem_zero
      logic [DATA_W-1:0] mem [DEPTH] = '{default: {DATA_W{1'b0}}};
      always_ff @(posedge clk) begin
        if (commit && op_wr) mem[addr_l] <= wdata_l;
      end
      assign mem_q = mem[addr_l];
    end else begin : g_mem_raw
      logic [DATA_W-1:0] mem [DEPTH];
      always_ff @(posedge clk) begin
        if (commit && op_wr) mem[addr_l] <= wdata_l;
      end
      assign mem_q = mem[addr_l];
    end
  endgenerate

endmodule
